// File: rtl/isa_pkg.sv
// rtl/isa_pkg.sv - shared ISA definitions: opcode classes, field positions, sequencer states
package isa_pkg;

   // Opcode classes
   localparam logic [3:0] OP_NOP     = 4'h0;
   localparam logic [3:0] OP_JMP     = 4'hE;
   localparam logic [3:0] OP_HALT    = 4'hF;
   localparam logic [3:0] OP_ALU_MIN = 4'h1;
   localparam logic [3:0] OP_ALU_MAX = 4'hD;

   // Instruction word field positions
   localparam int OPC_HI = 15;
   localparam int OPC_LO = 12;
   localparam int P1_HI  = 11;
   localparam int P1_LO  = 6;
   localparam int P2_HI  = 5;
   localparam int P2_LO  = 0;

   // Fetch/decode sequencer states
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_WAIT_MEM,
      ST_DECODE,
      ST_DISPATCH,
      ST_WAIT_DONE,
      ST_HALT
   } state_t;

   // True for opcodes that are forwarded to the ALU sequencer
   function automatic logic is_alu_op(input logic [3:0] op);
      return (op >= OP_ALU_MIN) && (op <= OP_ALU_MAX);
   endfunction

endpackage

// File: rtl/instr_decode_fsm.sv
// rtl/instr_decode_fsm.sv - fetch/decode sequencer dispatching ALU ops with done watchdog
module instr_decode_fsm #(
   parameter int ADDR_W  = 8,
   parameter int TIMEOUT = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              run,
   output logic [ADDR_W-1:0] instr_addr,
   output logic              instr_rd_en,
   input  logic [15:0]       instr_data,
   output logic              alu_start,
   output logic [3:0]        opcode,
   output logic [5:0]        param1,
   output logic [5:0]        param2,
   input  logic              alu_done,
   output logic [ADDR_W-1:0] pc,
   output logic              busy,
   output logic              halted,
   output logic              timeout_err
);
   import isa_pkg::*;

   localparam int              WD_W    = $clog2(TIMEOUT + 1);
   // Value of the watchdog during the last permitted WAIT_DONE cycle
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

   state_t            state;
   state_t            state_nxt;
   state_t            next_boundary;
   logic [ADDR_W-1:0] pc_nxt;
   logic [ADDR_W-1:0] pc_inc;
   logic [ADDR_W-1:0] jmp_target;
   logic [WD_W-1:0]   wd_cnt;
   logic              wd_expire;

   // Wraps naturally modulo 2^ADDR_W
   assign pc_inc        = pc + ADDR_W'(1);
   // Jump target is the low ADDR_W bits of the concatenated parameters
   assign jmp_target    = ADDR_W'({param1, param2});
   // Instruction boundary: continue only while run is held
   assign next_boundary = run ? ST_FETCH : ST_IDLE;

   // Next-state and next-pc selection; opcode/params already hold the fetched word in DECODE
   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      wd_expire = 1'b0;
      case (state)
         ST_IDLE: begin
            if (run) state_nxt = ST_FETCH;
         end
         ST_FETCH: begin
            state_nxt = ST_WAIT_MEM;
         end
         ST_WAIT_MEM: begin
            state_nxt = ST_DECODE;
         end
         ST_DECODE: begin
            case (opcode)
               OP_NOP: begin
                  pc_nxt    = pc_inc;
                  state_nxt = next_boundary;
               end
               OP_JMP: begin
                  pc_nxt    = jmp_target;
                  state_nxt = next_boundary;
               end
               OP_HALT: begin
                  state_nxt = ST_HALT;
               end
               default: begin
                  state_nxt = is_alu_op(opcode) ? ST_DISPATCH : ST_HALT;
               end
            endcase
         end
         ST_DISPATCH: begin
            state_nxt = ST_WAIT_DONE;
         end
         ST_WAIT_DONE: begin
            // A done in the final permitted cycle still wins over the watchdog
            if (alu_done) begin
               pc_nxt    = pc_inc;
               state_nxt = next_boundary;
            end else if (wd_cnt == WD_LAST) begin
               wd_expire = 1'b1;
               state_nxt = ST_HALT;
            end
         end
         ST_HALT: begin
            state_nxt = ST_HALT;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // State, pc, instruction register, watchdog and registered outputs derived from the next state
   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= ST_IDLE;
         pc          <= '0;
         instr_addr  <= '0;
         instr_rd_en <= 1'b0;
         alu_start   <= 1'b0;
         opcode      <= '0;
         param1      <= '0;
         param2      <= '0;
         busy        <= 1'b0;
         halted      <= 1'b0;
         timeout_err <= 1'b0;
         wd_cnt      <= '0;
      end else begin
         state       <= state_nxt;
         pc          <= pc_nxt;
         instr_rd_en <= (state_nxt == ST_FETCH);
         alu_start   <= (state_nxt == ST_DISPATCH);
         busy        <= (state_nxt != ST_IDLE) && (state_nxt != ST_HALT);
         halted      <= (state_nxt == ST_HALT);

         // ROM address tracks the pc being fetched and holds otherwise
         if (state_nxt == ST_FETCH) instr_addr <= pc_nxt;

         // Instruction register loads once per fetch, so fields stay stable through the ALU op
         if (state == ST_WAIT_MEM) begin
            opcode <= instr_data[OPC_HI:OPC_LO];
            param1 <= instr_data[P1_HI:P1_LO];
            param2 <= instr_data[P2_HI:P2_LO];
         end

         if (state == ST_DISPATCH) begin
            wd_cnt <= '0;
         end else if ((state == ST_WAIT_DONE) && !alu_done && (wd_cnt != WD_LAST)) begin
            wd_cnt <= wd_cnt + WD_W'(1);
         end

         if (wd_expire) timeout_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_instr_decode_fsm.sv
// tb/tb_instr_decode_fsm.sv - scoreboard bench for instr_decode_fsm with ISA reference model
module tb_instr_decode_fsm;

   localparam int AW = 8;
   localparam int TO = 32;

   localparam logic [1:0] EV_FETCH = 2'd0;
   localparam logic [1:0] EV_START = 2'd1;
   localparam logic [1:0] EV_HALT  = 2'd2;

   typedef struct packed {
      logic [1:0]  kind;
      logic [15:0] t;
      logic [7:0]  a;
      logic [3:0]  op;
      logic [5:0]  p1;
      logic [5:0]  p2;
      logic        to;
   } ev_t;

   logic          clock;
   logic          reset;
   logic          run;
   logic [AW-1:0] instr_addr;
   logic          instr_rd_en;
   logic [15:0]   instr_data;
   logic          alu_start;
   logic [3:0]    opcode;
   logic [5:0]    param1;
   logic [5:0]    param2;
   logic          alu_done;
   logic [AW-1:0] pc;
   logic          busy;
   logic          halted;
   logic          timeout_err;

   logic          resp_done;
   logic          stray_done;
   assign alu_done = resp_done | stray_done;

   logic [15:0] rom [256];
   int          dly [64];
   int          resp_k;
   ev_t         exp_q [$];
   int          checks;
   int          errors;
   int          cyc;
   int          t0;
   int          ev_idx;
   bit          first_seen;
   bit          halt_seen;
   bit          mon_en;

   instr_decode_fsm #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
      .clock       (clock),
      .reset       (reset),
      .run         (run),
      .instr_addr  (instr_addr),
      .instr_rd_en (instr_rd_en),
      .instr_data  (instr_data),
      .alu_start   (alu_start),
      .opcode      (opcode),
      .param1      (param1),
      .param2      (param2),
      .alu_done    (alu_done),
      .pc          (pc),
      .busy        (busy),
      .halted      (halted),
      .timeout_err (timeout_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      cyc = 0;
      forever begin
         @(posedge clock);
         cyc++;
      end
   end

   // Synchronous ROM: data valid the cycle after the read strobe
   always @(posedge clock) begin
      if (instr_rd_en) instr_data <= rom[instr_addr];
   end

   // ALU stand-in: answers each start with done after dly[k] cycles
   initial begin
      int cnt;
      cnt = 0;
      resp_done = 1'b0;
      forever begin
         @(negedge clock);
         resp_done = 1'b0;
         if (reset) begin
            cnt = 0;
         end else begin
            if (cnt > 0) begin
               cnt--;
               if (cnt == 0) resp_done = 1'b1;
            end
            if (alu_start) begin
               cnt = dly[resp_k];
               resp_k++;
            end
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic mon_take(input ev_t act);
      ev_t e;
      checks++;
      ev_idx++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_event #%0d kind=%0d a=%h op=%h at cycle %0d", ev_idx, act.kind, act.a, act.op, cyc);
         return;
      end
      e = exp_q.pop_front();
      if (!first_seen) begin
         first_seen = 1'b1;
         t0 = cyc - int'(e.t);
      end
      act.t = 16'(cyc - t0);
      if (act != e) begin
         errors++;
         $display("FAIL event #%0d: got kind=%0d t=%0d a=%h op=%h p1=%h p2=%h to=%b, expected kind=%0d t=%0d a=%h op=%h p1=%h p2=%h to=%b",
                  ev_idx, act.kind, act.t, act.a, act.op, act.p1, act.p2, act.to,
                  e.kind, e.t, e.a, e.op, e.p1, e.p2, e.to);
      end
   endtask

   // Monitor: turns fetches, starts and the halt into events and checks them against the queue
   initial begin
      ev_t act;
      forever begin
         @(negedge clock);
         if (mon_en) begin
            if (instr_rd_en) begin
               act = '0; act.kind = EV_FETCH; act.a = instr_addr;
               mon_take(act);
            end
            if (alu_start) begin
               act = '0; act.kind = EV_START; act.op = opcode; act.p1 = param1; act.p2 = param2;
               mon_take(act);
            end
            if (halted && !halt_seen) begin
               halt_seen = 1'b1;
               act = '0; act.kind = EV_HALT; act.a = pc; act.to = timeout_err;
               mon_take(act);
            end
         end
      end
   end

   // Reference model: walks the program by ISA rules and the documented cycle costs
   task automatic build_expect(input int max_instr, output bit halts);
      logic [7:0]  p;
      logic [15:0] w;
      int          t;
      int          k;
      ev_t         e;
      p = 8'd0; t = 0; k = 0; halts = 1'b0;
      for (int n = 0; n < max_instr; n++) begin
         e = '0; e.kind = EV_FETCH; e.t = 16'(t); e.a = p;
         exp_q.push_back(e);
         w = rom[p];
         if (w[15:12] == 4'h0) begin
            p = p + 8'd1;
            t += 3;
         end else if (w[15:12] == 4'hE) begin
            p = w[7:0];
            t += 3;
         end else if (w[15:12] == 4'hF) begin
            e = '0; e.kind = EV_HALT; e.t = 16'(t + 3); e.a = p;
            exp_q.push_back(e);
            halts = 1'b1;
            break;
         end else begin
            e = '0; e.kind = EV_START; e.t = 16'(t + 3);
            e.op = w[15:12]; e.p1 = w[11:6]; e.p2 = w[5:0];
            exp_q.push_back(e);
            if (dly[k] <= TO) begin
               p = p + 8'd1;
               t += 4 + dly[k];
               k++;
            end else begin
               e = '0; e.kind = EV_HALT; e.t = 16'(t + 4 + TO); e.a = p; e.to = 1'b1;
               exp_q.push_back(e);
               halts = 1'b1;
               break;
            end
         end
      end
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 256; i++) rom[i] = 16'hF000;
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1;
      run   = 1'b0;
      repeat (2) @(negedge clock);
      reset  = 1'b0;
      resp_k = 0;
   endtask

   task automatic run_prog(input int max_instr, input string tag);
      bit halts;
      int guard;
      do_reset();
      exp_q.delete();
      first_seen = 1'b0;
      halt_seen  = 1'b0;
      build_expect(max_instr, halts);
      mon_en = 1'b1;
      run    = 1'b1;
      guard  = 0;
      while (exp_q.size() != 0 && guard < 3000) begin
         @(posedge clock);
         guard++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_drain: %0d events outstanding, required 0", tag, exp_q.size());
         exp_q.delete();
      end
      if (halts) repeat (6) @(posedge clock);
      mon_en = 1'b0;
      run    = 1'b0;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_pc"},          int'(pc),          0);
      chk({tag, "_instr_addr"},  int'(instr_addr),  0);
      chk({tag, "_instr_rd_en"}, int'(instr_rd_en), 0);
      chk({tag, "_alu_start"},   int'(alu_start),   0);
      chk({tag, "_opcode"},      int'(opcode),      0);
      chk({tag, "_param1"},      int'(param1),      0);
      chk({tag, "_param2"},      int'(param2),      0);
      chk({tag, "_busy"},        int'(busy),        0);
      chk({tag, "_halted"},      int'(halted),      0);
      chk({tag, "_timeout_err"}, int'(timeout_err), 0);
   endtask

   task automatic wait_start(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clock);
         if (alu_start) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      bit ok;
      int nf;
      int len;
      reset = 1'b1; run = 1'b0; stray_done = 1'b0; mon_en = 1'b0;
      checks = 0; errors = 0; ev_idx = 0; resp_k = 0;
      for (int i = 0; i < 64; i++) dly[i] = 1;
      clear_rom();
      repeat (3) @(negedge clock);
      chk_reset("por");
      reset = 1'b0;
      repeat (2) @(negedge clock);
      chk_reset("idle_norun");

      // ALU op answered after 9 cycles, then halt at pc 1
      clear_rom(); rom[0] = 16'h1042; rom[1] = 16'hF000; dly[0] = 9;
      run_prog(8, "alu9");

      // NOP, JMP 5, HALT
      clear_rom(); rom[0] = 16'h0000; rom[1] = 16'hE005; rom[5] = 16'hF000;
      run_prog(8, "nopjmp");

      // Watchdog expiry with done never returned
      clear_rom(); rom[0] = 16'h3555; dly[0] = 1000;
      run_prog(4, "timeout");

      // Done in the last permitted cycle, and one cycle too late
      clear_rom(); rom[0] = 16'h2041; rom[1] = 16'hF123; dly[0] = TO;
      run_prog(4, "wd_edge_ok");
      dly[0] = TO + 1;
      run_prog(4, "wd_edge_late");

      // pc wraps from 0xFF to 0x00
      clear_rom(); rom[0] = 16'hE0FF; rom[255] = 16'h0000;
      run_prog(3, "wrap");

      // run dropped during WAIT_DONE parks in IDLE at the next pc
      do_reset();
      clear_rom(); rom[0] = 16'h1042; rom[1] = 16'h0000; rom[2] = 16'hF000; dly[0] = 6;
      run = 1'b1;
      wait_start(ok);
      chk("rundrop_start_seen", int'(ok), 1);
      run = 1'b0;
      nf = 0;
      repeat (12) begin
         @(negedge clock);
         if (instr_rd_en) nf++;
      end
      chk("rundrop_fetches_idle", nf, 0);
      chk("rundrop_busy", int'(busy), 0);
      chk("rundrop_pc", int'(pc), 1);
      chk("rundrop_halted", int'(halted), 0);
      run = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         if (instr_rd_en) begin
            ok = 1'b1;
            break;
         end
      end
      chk("resume_fetch_seen", int'(ok), 1);
      chk("resume_fetch_addr", int'(instr_addr), 1);
      run = 1'b0;

      // reset in WAIT_DONE, then a stray done while idle
      do_reset();
      clear_rom(); rom[0] = 16'h1042; dly[0] = 1000;
      run = 1'b1;
      wait_start(ok);
      chk("rstmid_start_seen", int'(ok), 1);
      repeat (3) @(negedge clock);
      reset = 1'b1;
      run   = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      stray_done = 1'b1;
      @(negedge clock);
      stray_done = 1'b0;
      chk_reset("rstmid");
      repeat (4) @(negedge clock);
      chk_reset("stray");

      // Randomised forward-only programs with random done latencies
      for (int s = 0; s < 25; s++) begin
         clear_rom();
         len = $urandom_range(4, 12);
         for (int i = 0; i < len - 1; i++) begin
            case ($urandom_range(0, 9))
               0, 1:    rom[i] = 16'($urandom_range(0, 4095));
               2, 3:    rom[i] = {4'hE, 4'($urandom_range(0, 15)), 8'($urandom_range(i + 1, len - 1))};
               default: rom[i] = {4'($urandom_range(1, 13)), 12'($urandom_range(0, 4095))};
            endcase
         end
         rom[len - 1] = {4'hF, 12'($urandom_range(0, 4095))};
         for (int i = 0; i < 64; i++)
            dly[i] = ($urandom_range(0, 7) == 0) ? $urandom_range(30, 36) : $urandom_range(1, 10);
         run_prog(64, "rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/instr_decode_fsm.md
# instr_decode_fsm

Fetch/decode sequencer directly upstream of the ALU sequencing FSM. Reads 16-bit instruction words from a synchronous instruction ROM, splits each into opcode and two 6-bit register parameters, and handles NOP/JMP/HALT locally. Every other opcode is dispatched to the ALU FSM with a one-cycle start pulse, and the block waits for that FSM's `done` before advancing the PC.

## Interface
- `ADDR_W`, 8: instruction address / PC width.
- `TIMEOUT`, 32: maximum cycles in WAIT_DONE before an error halt.

Ports:
- `clock`  in  1: clock.
- `reset`  in  1: reset, synchronous, active-high.
- `run`  in  1: enables fetching. Sampled at every instruction boundary.
- `instr_addr`  out  ADDR_W: ROM address. Equals `pc` during FETCH.
- `instr_rd_en`  out  1: ROM read strobe. High in FETCH only.
- `instr_data`  in  16: ROM data. Valid the cycle after `instr_rd_en`.
- `alu_start`  out  1: one-cycle start pulse to the ALU FSM.
- `opcode`  out  4: instruction bits [15:12]. Held stable from DISPATCH until `alu_done`.
- `param1`  out  6: instruction bits [11:6]. Destination and source A. Held stable from DISPATCH until `alu_done`.
- `param2`  out  6: instruction bits [5:0]. Source B. Held stable from DISPATCH until `alu_done`.
- `alu_done`  in  1: completion pulse from the ALU FSM.
- `pc`  out  ADDR_W: current program counter.
- `busy`  out  1: high in every state except IDLE and HALT.
- `halted`  out  1: high in HALT.
- `timeout_err`  out  1: sticky. Set on watchdog expiry.

## Operation
- Opcode classes:
  - 4'h0: NOP.
  - 4'hE: JMP. Target = {param1,param2}[ADDR_W-1:0].
  - 4'hF: HALT.
  - 4'h1–4'hD: ALU operation, forwarded unchanged.
- States: IDLE, FETCH, WAIT_MEM, DECODE, DISPATCH, WAIT_DONE, HALT.
- IDLE: if `run` is high, go to FETCH.
- FETCH: drive `instr_addr`=`pc` and `instr_rd_en`=1. Go to WAIT_MEM.
- WAIT_MEM: load `instr_data` into the instruction register. Go to DECODE.
- DECODE:
  - NOP: `pc`<=`pc`+1, then go to NEXT.
  - JMP: `pc`<=target, then go to NEXT.
  - HALT: go to HALT. `pc` is unchanged.
  - ALU: go to DISPATCH.
- DISPATCH: `alu_start`=1. Clear the watchdog. Go to WAIT_DONE.
- WAIT_DONE:
  - On `alu_done`: `pc`<=`pc`+1, then go to NEXT.
  - Otherwise the watchdog counts up. At TIMEOUT cycles: set `timeout_err` and go to HALT.
- NEXT means FETCH if `run`=1, else IDLE.
- HALT is terminal. Only `reset` exits it.
- `pc` increments modulo 2^ADDR_W, so 0xFF+1 = 0x00 at ADDR_W=8.

## Timing
- Reset values: `pc`=0; `instr_addr`=0; `instr_rd_en`=0; `alu_start`=0; `opcode`=0; `param1`=0; `param2`=0; `busy`=0; `halted`=0; `timeout_err`=0; state=IDLE.
- Latency, measured from the FETCH cycle to the next FETCH cycle with `run` held high:
  - NOP or JMP: 3 cycles.
  - ALU instruction: 4 cycles + N, where N is the number of WAIT_DONE cycles up to and including the `alu_done` cycle.
- `alu_start` is exactly one cycle wide. It is never reasserted before `alu_done`.
- `alu_done` is ignored in every state except WAIT_DONE, including a `done` that coincides with DISPATCH.
- `opcode`, `param1` and `param2` are registered outputs of the instruction register. They change only in the cycle after WAIT_MEM.
- Deasserting `run` mid-instruction does not abort it. The instruction completes and the block parks in IDLE with `pc` pointing at the next instruction.
- `reset` mid-operation returns the block to IDLE with reset values on the next edge. The ALU FSM shares the same `reset`, so no handshake is left dangling.
- Watchdog boundary: `alu_done` arriving in the TIMEOUT-th WAIT_DONE cycle counts as success. The error is raised only when that cycle passes without `done`.

## Structure
- Shared package `isa_pkg` holds:
  - opcode constants OP_NOP, OP_JMP, OP_HALT, and the ALU opcode range;
  - field bit positions;
  - the state enum.
  The ALU FSM and the assembler tests use the same package.
- No sub-module is needed. The watchdog counter (width $clog2(TIMEOUT+1)) stays inline.

## Test plan
- ROM[0]=16'h1042 (opcode 1, param1=1, param2=2), `run`=1, `alu_done` returned 9 cycles after `alu_start`:
  - `alu_start` pulses once, with `opcode`=1, `param1`=1, `param2`=2;
  - `pc`=1 after `done`;
  - the next FETCH occurs on the cycle after `done`.
- ROM[0]=16'h0000, ROM[1]=16'hE005, ROM[5]=16'hF000:
  - FETCH addresses seen are 0, 1, 5;
  - `halted`=1 with `pc`=5;
  - `alu_start` is never asserted.
- ALU instruction with `alu_done` held low:
  - exactly TIMEOUT=32 WAIT_DONE cycles, then `timeout_err`=1 and `halted`=1.
- `pc` preloaded to 0xFF via JMP to 8'hFF, ROM[0xFF]=NOP:
  - the next FETCH address is 0x00.
- `run` dropped during WAIT_DONE:
  - after `done`, state is IDLE with `pc` incremented and `busy`=0;
  - reasserting `run` resumes from that `pc`.
- `reset` asserted in WAIT_DONE, followed by a stray `alu_done` pulse:
  - all outputs return to reset values;
  - the stray `done` is ignored in IDLE.
